// File: rtl/cheri_btb_predictor_pkg.sv
// Shared CHERI BTB types: configuration constants, entry layout, flush FSM states
// and the PC field-extraction helpers used by the predictor.
package cheri_btb_predictor_pkg;

    localparam int unsigned NR_ENTRIES = 32;
    localparam int unsigned VLEN       = 64;
    localparam int unsigned META_W     = 64;
    localparam int unsigned TAG_W      = 16;
    localparam int unsigned ROW_OFFSET = 1;
    localparam int unsigned IDX_W      = $clog2(NR_ENTRIES);

    typedef logic [IDX_W-1:0] btb_idx_t;
    typedef logic [TAG_W-1:0] btb_tag_t;

    // Target bit 0 is architecturally zero, so only VLEN-1 bits are stored.
    typedef struct packed {
        logic              valid;
        btb_tag_t          tag;
        logic [VLEN-2:0]   target;
        logic [META_W-1:0] meta;
    } btb_entry_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } btb_state_e;

    function automatic btb_idx_t btb_index(input logic [VLEN-1:0] pc);
        return pc[ROW_OFFSET +: IDX_W];
    endfunction

    function automatic btb_tag_t btb_tag(input logic [VLEN-1:0] pc);
        return pc[ROW_OFFSET + IDX_W +: TAG_W];
    endfunction

endpackage

// File: rtl/cheri_btb_predictor_if.sv
// Frontend-facing bundle of the BTB: lookup/predict, training stream and flush control.
interface cheri_btb_predictor_if;
    import cheri_btb_predictor_pkg::*;

    logic              debug_mode_i;
    logic              flush_bp_i;
    logic              busy_o;
    logic              lookup_valid_i;
    logic [VLEN-1:0]   lookup_pc_i;
    logic              predict_valid_o;
    logic [VLEN-1:0]   predict_target_o;
    logic [META_W-1:0] predict_meta_o;
    logic              upd_valid_i;
    logic              upd_mispredict_i;
    logic              upd_is_jumpr_i;
    logic [VLEN-1:0]   upd_pc_i;
    logic [VLEN-1:0]   upd_target_i;
    logic [META_W-1:0] upd_meta_i;

    modport slave (
        input  debug_mode_i, flush_bp_i, lookup_valid_i, lookup_pc_i,
        input  upd_valid_i, upd_mispredict_i, upd_is_jumpr_i, upd_pc_i, upd_target_i, upd_meta_i,
        output busy_o, predict_valid_o, predict_target_o, predict_meta_o
    );

    modport master (
        output debug_mode_i, flush_bp_i, lookup_valid_i, lookup_pc_i,
        output upd_valid_i, upd_mispredict_i, upd_is_jumpr_i, upd_pc_i, upd_target_i, upd_meta_i,
        input  busy_o, predict_valid_o, predict_target_o, predict_meta_o
    );

endinterface

// File: rtl/cheri_btb_ram.sv
// BTB payload storage: one synchronous read port, one write port, read-before-write.
module cheri_btb_ram #(
    parameter  int unsigned DEPTH  = 32,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array; validity lives in separate flops, so stale
    // payload is never observed and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking writes make a same-edge read see the old word,
        // which is exactly the read-before-write behaviour required here.
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cheri_btb_predictor.sv
// Direct-mapped BTB for capability jumps: 1-cycle lookup, trained on mispredicted
// JumpR, sequential one-entry-per-cycle flush.
module cheri_btb_predictor
    import cheri_btb_predictor_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cheri_btb_predictor_if.slave  bus
);

    localparam int unsigned DATA_W = $bits(btb_entry_t) - 1;

    btb_state_e            state_q;
    logic                  busy_q;
    btb_idx_t              flush_cnt_q;
    logic [NR_ENTRIES-1:0] valid_q;

    logic                  lookup_req_q;
    logic                  entry_valid_q;
    btb_tag_t              lookup_tag_q;
    logic [VLEN-1:0]       target_q;
    logic [META_W-1:0]     meta_q;

    btb_idx_t              lookup_idx;
    btb_idx_t              upd_idx;
    logic                  train;
    logic                  hit;
    btb_entry_t            wr_entry;
    btb_entry_t            rd_entry;
    logic [DATA_W-1:0]     rd_data;

    assign lookup_idx = btb_index(bus.lookup_pc_i);
    assign upd_idx    = btb_index(bus.upd_pc_i);

    // Only mispredicted JumpR outside debug mode trains; updates while flushing are dropped.
    assign train = bus.upd_valid_i && bus.upd_mispredict_i && bus.upd_is_jumpr_i
                && !bus.debug_mode_i && (state_q == IDLE);

    assign wr_entry = '{
        valid:  1'b1,
        tag:    btb_tag(bus.upd_pc_i),
        target: bus.upd_target_i[VLEN-1:1],
        meta:   bus.upd_meta_i
    };

    cheri_btb_ram #(
        .DEPTH  (NR_ENTRIES),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (train),
        .waddr (upd_idx),
        .wdata (wr_entry[DATA_W-1:0]),
        .re    (bus.lookup_valid_i),
        .raddr (lookup_idx),
        .rdata (rd_data)
    );

    // The valid bit is sampled alongside the RAM read so both reflect the same edge.
    assign rd_entry = {entry_valid_q, rd_data};
    assign hit      = lookup_req_q && rd_entry.valid && (rd_entry.tag == lookup_tag_q);

    assign bus.predict_valid_o  = hit;
    assign bus.predict_target_o = hit ? {rd_entry.target, 1'b0} : target_q;
    assign bus.predict_meta_o   = hit ? rd_entry.meta : meta_q;
    assign bus.busy_o           = busy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            flush_cnt_q   <= '0;
            valid_q       <= '0;
            lookup_req_q  <= 1'b0;
            entry_valid_q <= 1'b0;
            lookup_tag_q  <= '0;
            target_q      <= '0;
            meta_q        <= '0;
        end else begin
            lookup_req_q  <= bus.lookup_valid_i && (state_q == IDLE);
            entry_valid_q <= valid_q[lookup_idx];
            lookup_tag_q  <= btb_tag(bus.lookup_pc_i);

            // Hold the last prediction so the outputs stay stable across misses.
            if (hit) begin
                target_q <= {rd_entry.target, 1'b0};
                meta_q   <= rd_entry.meta;
            end

            if (train) begin
                valid_q[upd_idx] <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.flush_bp_i) begin
                        state_q     <= FLUSH;
                        busy_q      <= 1'b1;
                        flush_cnt_q <= '0;
                    end
                end
                FLUSH: begin
                    valid_q[flush_cnt_q] <= 1'b0;
                    if (bus.flush_bp_i) begin
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == btb_idx_t'(NR_ENTRIES - 1)) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cheri_btb_predictor.sv
// Self-checking bench for cheri_btb_predictor: directed scenarios plus a randomized
// run compared against an array-based reference model.
module tb_cheri_btb_predictor;
    import cheri_btb_predictor_pkg::*;

    localparam int NR = NR_ENTRIES;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;

    cheri_btb_predictor_if bus ();

    cheri_btb_predictor dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Reference model: table contents as plain arrays plus remaining flush cycles.
    bit          m_valid  [NR];
    logic [15:0] m_tag    [NR];
    logic [63:0] m_target [NR];
    logic [63:0] m_meta   [NR];
    int          m_flush_left = 0;
    int          m_flush_pos  = 0;
    logic        exp_valid  = 1'b0;
    logic [63:0] exp_target = '0;
    logic [63:0] exp_meta   = '0;
    logic        exp_busy   = 1'b0;

    function automatic int pc_index(input logic [63:0] pc);
        return int'((pc / 64'd2) % 64'(NR));
    endfunction

    function automatic logic [15:0] pc_tag(input logic [63:0] pc);
        return 16'((pc / (64'd2 * 64'(NR))) % 64'd65536);
    endfunction

    task automatic idle_inputs();
        bus.debug_mode_i     = 1'b0;
        bus.flush_bp_i       = 1'b0;
        bus.lookup_valid_i   = 1'b0;
        bus.lookup_pc_i      = '0;
        bus.upd_valid_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
        bus.upd_is_jumpr_i   = 1'b0;
        bus.upd_pc_i         = '0;
        bus.upd_target_i     = '0;
        bus.upd_meta_i       = '0;
    endtask

    task automatic set_update(input logic [63:0] pc, input logic [63:0] target,
                              input logic [63:0] meta, input logic jumpr, input logic dbg);
        bus.upd_valid_i      = 1'b1;
        bus.upd_mispredict_i = 1'b1;
        bus.upd_is_jumpr_i   = jumpr;
        bus.debug_mode_i     = dbg;
        bus.upd_pc_i         = pc;
        bus.upd_target_i     = target;
        bus.upd_meta_i       = meta;
    endtask

    task automatic clear_update();
        bus.upd_valid_i  = 1'b0;
        bus.debug_mode_i = 1'b0;
    endtask

    task automatic set_lookup(input logic en, input logic [63:0] pc);
        bus.lookup_valid_i = en;
        bus.lookup_pc_i    = pc;
    endtask

    // Advances the model by one clock using the current inputs, then advances the DUT.
    task automatic step();
        int  li, ui;
        bit  busy_now, hit, train;
        busy_now = (m_flush_left > 0);
        if (!rst_ni) begin
            for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
            m_flush_left = 0;
            m_flush_pos  = 0;
            exp_valid    = 1'b0;
            exp_target   = '0;
            exp_meta     = '0;
        end else begin
            li  = pc_index(bus.lookup_pc_i);
            ui  = pc_index(bus.upd_pc_i);
            hit = bus.lookup_valid_i && !busy_now && m_valid[li]
                  && (m_tag[li] == pc_tag(bus.lookup_pc_i));
            exp_valid = hit;
            if (hit) begin
                exp_target = m_target[li];
                exp_meta   = m_meta[li];
            end
            train = bus.upd_valid_i && bus.upd_mispredict_i && bus.upd_is_jumpr_i
                    && !bus.debug_mode_i && !busy_now;
            if (busy_now) begin
                m_valid[m_flush_pos] = 1'b0;
                if (bus.flush_bp_i) begin
                    m_flush_pos  = 0;
                    m_flush_left = NR;
                end else begin
                    m_flush_pos++;
                    m_flush_left--;
                end
            end else if (bus.flush_bp_i) begin
                m_flush_pos  = 0;
                m_flush_left = NR;
            end
            if (train) begin
                m_valid[ui]  = 1'b1;
                m_tag[ui]    = pc_tag(bus.upd_pc_i);
                m_target[ui] = bus.upd_target_i & ~64'd1;
                m_meta[ui]   = bus.upd_meta_i;
            end
        end
        exp_busy = (m_flush_left > 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy_o); end
        checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.predict_valid_o); end
        checks++; if (bus.predict_target_o !== 64'd0) begin errors++; $display("FAIL reset_target: got %h want 0", bus.predict_target_o); end
        checks++; if (bus.predict_meta_o !== 64'd0) begin errors++; $display("FAIL reset_meta: got %h want 0", bus.predict_meta_o); end
        set_lookup(1'b1, 64'h8000_0010);
        step();
        set_lookup(1'b0, '0);
        checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL reset_lookup_miss: got %0b want 0", bus.predict_valid_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_lookup_busy: got %0b want 0", bus.busy_o); end
    endtask

    task automatic test_train();
        set_update(64'h8000_0010, 64'h8000_2001, 64'hABCD, 1'b1, 1'b0);
        step();
        clear_update();
        set_lookup(1'b1, 64'h8000_0010);
        step();
        set_lookup(1'b0, '0);
        checks++; if (bus.predict_valid_o !== 1'b1) begin errors++; $display("FAIL train_hit: got %0b want 1", bus.predict_valid_o); end
        checks++; if (bus.predict_target_o !== 64'h8000_2000) begin errors++; $display("FAIL train_target: got %h want 80002000", bus.predict_target_o); end
        checks++; if (bus.predict_meta_o !== 64'hABCD) begin errors++; $display("FAIL train_meta: got %h want abcd", bus.predict_meta_o); end
        step();
        checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL train_no_request: got %0b want 0", bus.predict_valid_o); end
        checks++; if (bus.predict_target_o !== 64'h8000_2000) begin errors++; $display("FAIL train_target_hold: got %h want 80002000", bus.predict_target_o); end
    endtask

    task automatic test_no_train();
        logic [63:0] pc;
        pc = 64'h8000_0100;
        for (int k = 0; k < 3; k++) begin
            set_update(pc, 64'h9000_0000, 64'h1234, (k != 1), (k == 0));
            if (k == 2) bus.upd_mispredict_i = 1'b0;
            step();
            clear_update();
            set_lookup(1'b1, pc);
            step();
            set_lookup(1'b0, '0);
            checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL no_train_case%0d: got %0b want 0", k, bus.predict_valid_o); end
        end
    endtask

    task automatic test_alias();
        logic [63:0] pc_a, pc_b;
        pc_a = 64'h8000_0024;
        pc_b = pc_a + 64'(2 * NR);
        set_update(pc_a, 64'h0000_1000, 64'h11, 1'b1, 1'b0);
        step();
        set_update(pc_b, 64'h0000_2000, 64'h22, 1'b1, 1'b0);
        step();
        clear_update();
        set_lookup(1'b1, pc_a);
        step();
        checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL alias_a_miss: got %0b want 0", bus.predict_valid_o); end
        set_lookup(1'b1, pc_b);
        step();
        set_lookup(1'b0, '0);
        checks++; if (bus.predict_valid_o !== 1'b1) begin errors++; $display("FAIL alias_b_hit: got %0b want 1", bus.predict_valid_o); end
        checks++; if (bus.predict_target_o !== 64'h0000_2000) begin errors++; $display("FAIL alias_b_target: got %h want 2000", bus.predict_target_o); end
        checks++; if (bus.predict_meta_o !== 64'h22) begin errors++; $display("FAIL alias_b_meta: got %h want 22", bus.predict_meta_o); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pc;
        pc = 64'h8000_0030;
        set_update(pc, 64'h0000_3000, 64'h33, 1'b1, 1'b0);
        set_lookup(1'b1, pc);
        step();
        clear_update();
        checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL rbw_old_data: got %0b want 0", bus.predict_valid_o); end
        step();
        set_lookup(1'b0, '0);
        checks++; if (bus.predict_valid_o !== 1'b1) begin errors++; $display("FAIL rbw_new_hit: got %0b want 1", bus.predict_valid_o); end
        checks++; if (bus.predict_target_o !== 64'h0000_3000) begin errors++; $display("FAIL rbw_new_target: got %h want 3000", bus.predict_target_o); end
    endtask

    task automatic test_flush();
        logic [63:0] pcs [4];
        logic [63:0] probe [6];
        int n;
        for (int k = 0; k < 4; k++) begin
            pcs[k] = 64'h8000_0200 + 64'(k * 2);
            set_update(pcs[k], 64'h0000_4000 + 64'(k * 16), 64'(k), 1'b1, 1'b0);
            step();
        end
        clear_update();
        set_lookup(1'b1, pcs[2]);
        step();
        checks++; if (bus.predict_valid_o !== 1'b1) begin errors++; $display("FAIL flush_pre_hit: got %0b want 1", bus.predict_valid_o); end
        set_lookup(1'b0, '0);
        bus.flush_bp_i = 1'b1;
        step();
        bus.flush_bp_i = 1'b0;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 100) begin
            n++;
            if (n == 5) set_update(64'h8000_0300, 64'h0000_5000, 64'h55, 1'b1, 1'b0);
            else clear_update();
            set_lookup(1'b1, pcs[n % 4]);
            step();
            checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL flush_lookup_miss cycle %0d: got %0b want 0", n, bus.predict_valid_o); end
        end
        clear_update();
        checks++; if (n !== NR) begin errors++; $display("FAIL flush_busy_cycles: got %0d want %0d", n, NR); end
        probe[0] = pcs[0]; probe[1] = pcs[1]; probe[2] = pcs[2]; probe[3] = pcs[3];
        probe[4] = 64'h8000_0300; probe[5] = 64'h8000_0010;
        for (int k = 0; k < 6; k++) begin
            set_lookup(1'b1, probe[k]);
            step();
            checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after_miss pc=%h: got %0b want 0", probe[k], bus.predict_valid_o); end
        end
        set_lookup(1'b0, '0);
        // Reset in the middle of a second flush aborts it immediately.
        bus.flush_bp_i = 1'b1;
        step();
        bus.flush_bp_i = 1'b0;
        for (int k = 1; k < 10; k++) step();
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL flush_busy_before_reset: got %0b want 1", bus.busy_o); end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_reset_abort: got %0b want 0", bus.busy_o); end
        set_lookup(1'b1, 64'h8000_0024 + 64'(2 * NR));
        step();
        set_lookup(1'b0, '0);
        checks++; if (bus.predict_valid_o !== 1'b0) begin errors++; $display("FAIL reset_clears_table: got %0b want 0", bus.predict_valid_o); end
    endtask

    task automatic test_random();
        logic [63:0] pc;
        for (int c = 0; c < 600; c++) begin
            pc = 64'h8000_0000 + 64'($urandom_range(0, 1) * 2 * NR) + 64'($urandom_range(0, 7) * 2);
            set_lookup(($urandom_range(0, 3) != 0), pc);
            pc = 64'h8000_0000 + 64'($urandom_range(0, 1) * 2 * NR) + 64'($urandom_range(0, 7) * 2);
            bus.upd_valid_i      = ($urandom_range(0, 1) == 1);
            bus.upd_mispredict_i = ($urandom_range(0, 3) != 0);
            bus.upd_is_jumpr_i   = ($urandom_range(0, 3) != 0);
            bus.debug_mode_i     = ($urandom_range(0, 7) == 0);
            bus.upd_pc_i         = pc;
            bus.upd_target_i     = {$urandom, $urandom};
            bus.upd_meta_i       = {$urandom, $urandom};
            bus.flush_bp_i       = ($urandom_range(0, 149) == 0);
            step();
            checks++; if (bus.predict_valid_o !== exp_valid) begin errors++; $display("FAIL rand_valid cycle %0d: got %0b want %0b", c, bus.predict_valid_o, exp_valid); end
            checks++; if (bus.predict_target_o !== exp_target) begin errors++; $display("FAIL rand_target cycle %0d: got %h want %h", c, bus.predict_target_o, exp_target); end
            checks++; if (bus.predict_meta_o !== exp_meta) begin errors++; $display("FAIL rand_meta cycle %0d: got %h want %h", c, bus.predict_meta_o, exp_meta); end
            checks++; if (bus.busy_o !== exp_busy) begin errors++; $display("FAIL rand_busy cycle %0d: got %0b want %0b", c, bus.busy_o, exp_busy); end
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_train();
        test_no_train();
        test_alias();
        test_back_to_back();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
